// File: rtl/serie_paralelo_alineado.sv
// Serial-to-parallel converter with comma-based word alignment and a lock state machine.
// Latency: zero cycles, so valid_out and parallel_out update on the edge that samples a word's last bit. No backpressure: the serial input is never stalled.
module serie_paralelo_alineado #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             locked,
    output logic             lock_lost
);

    localparam int             BCW      = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [3:0]     LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0]     LOSS_N   = 4'(LOSS_COUNT);

    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]       comma_cnt_q, comma_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    logic [WIDTH-1:0] cand;
    logic             is_comma;
    logic             at_boundary;
    logic [3:0]       comma_inc;
    logic [3:0]       miss_inc;

    // cand already includes this cycle's bit, so a word is decided on its last bit.
    always_comb begin
        cand        = {shift_q[WIDTH-2:0], data_in};
        is_comma    = (cand == COMMA);
        at_boundary = (bit_cnt_q == LAST_BIT);
        comma_inc   = (comma_cnt_q == 4'hF) ? comma_cnt_q : comma_cnt_q + 4'd1;
        miss_inc    = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= 1'b0;
            par_q       <= '0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            par_q       <= par_d;
            locked_q    <= locked_d;
            lost_q      <= lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = cand;
        bit_cnt_d   = at_boundary ? '0 : bit_cnt_q + BCW'(1);
        comma_cnt_d = comma_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    miss_cnt_d  = '0;
                    state_d     = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (at_boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (is_comma) begin
                    if (at_boundary) begin
                        miss_cnt_d = '0;
                    end else if (miss_inc >= LOSS_N) begin
                        // The losing comma is consumed here; HUNT starts fresh next cycle.
                        state_d     = HUNT;
                        miss_cnt_d  = '0;
                        comma_cnt_d = '0;
                        bit_cnt_d   = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        valid_d  = (state_q == LOCKED) && at_boundary && !is_comma;
        par_d    = valid_d ? cand : par_q;
        locked_d = (state_d == LOCKED);
        lost_d   = (state_q == LOCKED) && (state_d == HUNT);
    end

    assign valid_out    = valid_q;
    assign parallel_out = par_q;
    assign locked       = locked_q;
    assign lock_lost    = lost_q;

endmodule

// File: tb/tb_serie_paralelo_alineado.sv
// Scoreboard bench for serie_paralelo_alineado: a default 8-bit instance and a 10-bit, LOCK_COUNT=2 instance.
module tb_serie_paralelo_alineado;

    localparam int K_VALID = 0;
    localparam int K_RISE  = 1;
    localparam int K_FALL  = 2;
    localparam int K_LOST  = 3;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1, rst10 = 1'b1;
    logic       din8 = 1'b0, din10 = 1'b0;
    logic       v8, lk8, ll8;
    logic [7:0] p8;
    logic       v10, lk10, ll10;
    logic [9:0] p10;

    int   cyc = 0;
    int   t0 = 0;
    int   tests = 0;
    int   failed = 0;
    bit   stim[$];
    exp_t q8[$];
    exp_t q10[$];
    logic prev8 = 1'b0, prev10 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serie_paralelo_alineado dut8 (
        .clk_8f(clk), .reset(rst8), .data_in(din8),
        .valid_out(v8), .parallel_out(p8), .locked(lk8), .lock_lost(ll8)
    );

    serie_paralelo_alineado #(
        .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .LOSS_COUNT(3)
    ) dut10 (
        .clk_8f(clk), .reset(rst10), .data_in(din10),
        .valid_out(v10), .parallel_out(p10), .locked(lk10), .lock_lost(ll10)
    );

    task automatic check_evt(input int id, input int kind, input logic [15:0] d);
        exp_t e;
        tests++;
        if ((id == 0 && q8.size() == 0) || (id == 1 && q10.size() == 0)) begin
            failed++;
            $display("FAIL unexpected_event dut%0d: got kind=%0d data=%h cyc=%0d, required no event",
                     id, kind, d, cyc);
        end else begin
            if (id == 0) e = q8.pop_front();
            else         e = q10.pop_front();
            if (e.kind != kind || e.data !== d || e.cyc != cyc) begin
                failed++;
                $display("FAIL event dut%0d: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                         id, kind, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst8) begin
            prev8 = 1'b0;
        end else begin
            if (v8)           check_evt(0, K_VALID, 16'(p8));
            if (lk8 && !prev8) check_evt(0, K_RISE, 16'h0);
            if (!lk8 && prev8) check_evt(0, K_FALL, 16'h0);
            if (ll8)          check_evt(0, K_LOST, 16'h0);
            prev8 = lk8;
        end
    end

    always @(negedge clk) begin
        if (rst10) begin
            prev10 = 1'b0;
        end else begin
            if (v10)             check_evt(1, K_VALID, 16'(p10));
            if (lk10 && !prev10) check_evt(1, K_RISE, 16'h0);
            if (!lk10 && prev10) check_evt(1, K_FALL, 16'h0);
            if (ll10)            check_evt(1, K_LOST, 16'h0);
            prev10 = lk10;
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic begin_seq();
        stim.delete();
        t0 = cyc;
    endtask

    task automatic add(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(w[i]);
    endtask

    task automatic expect_evt(input int id, input int kind, input logic [15:0] d, input int off);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = t0 + off;
        if (id == 0) q8.push_back(e);
        else         q10.push_back(e);
    endtask

    task automatic send(input int id);
        for (int i = 0; i < stim.size(); i++) begin
            if (id == 0) din8 = stim[i];
            else         din10 = stim[i];
            @(negedge clk);
        end
        din8  = 1'b0;
        din10 = 1'b0;
    endtask

    task automatic reset8();
        #2 rst8 = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("reset_valid", 16'(v8), 16'h0);
        chk("reset_par", 16'(p8), 16'h0);
        chk("reset_locked", 16'(lk8), 16'h0);
        chk("reset_lost", 16'(ll8), 16'h0);
        chk("reset10_outs", {v10, lk10, ll10, 3'b0, p10}, 16'h0);
        @(negedge clk);
        #2 rst8 = 1'b0;
        rst10 = 1'b0;
        @(negedge clk);

        // Lock after four commas, then two data words
        begin_seq();
        add(16'h5, 3);
        repeat (4) add(16'hBC, 8);
        add(16'h5A, 8);
        add(16'h3C, 8);
        expect_evt(0, K_RISE, 16'h0, 35);
        expect_evt(0, K_VALID, 16'h5A, 43);
        expect_evt(0, K_VALID, 16'h3C, 51);
        send(0);
        @(negedge clk);
        chk("par_held", 16'(p8), 16'h3C);
        chk("strobe_one_cycle", 16'(v8), 16'h0);

        // Broken alignment: a data word after two commas restarts the count
        reset8();
        begin_seq();
        repeat (2) add(16'hBC, 8);
        add(16'h00, 8);
        repeat (4) add(16'hBC, 8);
        expect_evt(0, K_RISE, 16'h0, 56);
        send(0);

        // One-bit slip: three misaligned commas drop lock, then relock
        begin_seq();
        add(16'h0, 1);
        repeat (3) add(16'hBC, 8);
        repeat (4) add(16'hBC, 8);
        add(16'h5A, 8);
        expect_evt(0, K_VALID, 16'h5E, 8);
        expect_evt(0, K_VALID, 16'h5E, 16);
        expect_evt(0, K_VALID, 16'h5E, 24);
        expect_evt(0, K_FALL, 16'h0, 25);
        expect_evt(0, K_LOST, 16'h0, 25);
        expect_evt(0, K_RISE, 16'h0, 57);
        expect_evt(0, K_VALID, 16'h5A, 65);
        send(0);

        // Two misses, an aligned comma clears them, two more misses keep lock
        begin_seq();
        add(16'h0, 1);
        repeat (2) add(16'hBC, 8);
        add(16'h0, 7);
        add(16'hBC, 8);
        add(16'h0, 1);
        repeat (2) add(16'hBC, 8);
        add(16'h0, 7);
        expect_evt(0, K_VALID, 16'h5E, 8);
        expect_evt(0, K_VALID, 16'h5E, 16);
        expect_evt(0, K_VALID, 16'h00, 24);
        expect_evt(0, K_VALID, 16'h5E, 40);
        expect_evt(0, K_VALID, 16'h5E, 48);
        expect_evt(0, K_VALID, 16'h00, 56);
        send(0);
        chk("miss_cleared_locked", 16'(lk8), 16'h1);

        // Asynchronous reset mid-word while locked
        begin_seq();
        add(16'hA5, 8);
        add(16'h6, 3);
        expect_evt(0, K_VALID, 16'hA5, 8);
        send(0);
        #2 rst8 = 1'b1;
        #1;
        chk("async_valid", 16'(v8), 16'h0);
        chk("async_par", 16'(p8), 16'h0);
        chk("async_locked", 16'(lk8), 16'h0);
        chk("async_lost", 16'(ll8), 16'h0);
        repeat (2) @(negedge clk);
        #2 rst8 = 1'b0;
        @(negedge clk);
        begin_seq();
        add(16'h5A, 8);
        add(16'h00, 8);
        repeat (4) add(16'hBC, 8);
        add(16'h3C, 8);
        expect_evt(0, K_RISE, 16'h0, 48);
        expect_evt(0, K_VALID, 16'h3C, 56);
        send(0);
        reset8();

        // 10-bit instance, lock after two commas
        begin_seq();
        repeat (2) add(16'h17C, 10);
        add(16'h2A5, 10);
        expect_evt(1, K_RISE, 16'h0, 20);
        expect_evt(1, K_VALID, 16'h2A5, 30);
        send(1);
        #2;
        chk("missing_events_dut8", 16'(q8.size()), 16'h0);
        chk("missing_events_dut10", 16'(q10.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
